inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Parametrised direct-mapped instruction cache. It is the successor to the flat instruction RAM and sits between the PC/fetch stage and a slower backing instruction memory (on-chip RAM or the JTAG-loaded store).
- Serves hits with 1-cycle latency at one fetch per cycle.
- Refills whole lines through a beat-by-beat memory handshake.
- Supports full invalidation (fence.i / after program download).

Parameters:
- ADDR_W, 32, fetch/memory byte-address width.
- LINE_WORDS, 4, 32-bit words per line; power of 2, ≥2.
- LINES, 64, number of cache lines; power of 2, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_ready  out  1  cache can accept a request this cycle.
- cpu_rvalid  out  1  cpu_rdata valid (1-cycle pulse per accepted request).
- cpu_rdata  out  32  fetched instruction word.
- flush  in  1  invalidate all lines (level, sampled per cycle).
- mem_req  out  1  refill beat request, level.
- mem_addr  out  ADDR_W  word-aligned address of the requested beat.
- mem_rvalid  in  1  backing memory returns the current beat.
- mem_rdata  in  32  beat data.

Behaviour:
- Address split: OFF_W=log2(LINE_WORDS), IDX_W=log2(LINES).
  - word offset = addr[OFF_W+1:2]
  - index = addr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = remaining upper bits.
- Storage:
  - data array: synchronous-read RAM, LINES*LINE_WORDS x 32.
  - tag array + valid vector in flops.
- Reset (async, rst_n=0): state=IDLE, all valid bits 0, cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, mem_req=0, mem_addr=0, beat counter=0, flush_pending=0.
- FSM states: IDLE, REFILL, RESP, FLUSH.
- IDLE:
  - cpu_ready=1.
  - flush=1 has priority: request not accepted (cpu_ready=0 that cycle) -> FLUSH.
  - Request accepted on cpu_req&cpu_ready at cycle N: register address, start data-array read at the same index/offset.
  - Cycle N+1, tag compare on the registered address:
    - Hit (valid & tag equal): cpu_rvalid=1 and cpu_rdata=RAM output in N+1. cpu_ready stays 1, so back-to-back hits sustain 1/cycle.
    - Miss: cpu_rvalid=0, cpu_ready=0, any request presented in N+1 is not accepted -> REFILL, beat counter=0.
- REFILL:
  - mem_req=1; mem_addr = {tag,index,counter,2'b00}, starting at the line base (no critical-word-first).
  - Each mem_rvalid: write mem_rdata to data array at {index,counter}; if counter==requested offset, capture into a response register; counter++.
  - mem_rvalid gaps of any length are tolerated; mem_req/mem_addr hold.
  - On the last beat (counter==LINE_WORDS-1 with mem_rvalid): write tag, set valid[index], drop mem_req next cycle -> RESP.
  - flush asserted during REFILL sets flush_pending; it does not abort the refill.
- RESP: cpu_rvalid=1 with the captured word for one cycle, cpu_ready=0. Next state is FLUSH if flush_pending or flush, else IDLE.
- FLUSH: all valid bits cleared in one cycle, flush_pending cleared, cpu_ready=0, -> IDLE.
- A miss in the same index overwrites (evicts) the resident line.
- Hit/refill paths must never both assert cpu_rvalid in one cycle.
- A miss never returns stale data.
- Reset mid-refill: mem_req drops immediately (async), line stays invalid. A late mem_rvalid after reset is ignored.
- Exactly one cpu_rvalid per accepted request, in request order.

Test Plan:
- Defaults. Reset, cpu_req with 0x0000_0000, memory returns 0xA0..0xA3 with no gaps.
  - mem_addr 0x0, 0x4, 0x8, 0xC.
  - cpu_rvalid with 0xA0 exactly 1 cycle after the 4th beat.
- Then fetch 0x4, 0x8, 0xC back-to-back.
  - cpu_rvalid on 3 consecutive cycles, data 0xA1, 0xA2, 0xA3, mem_req stays 0.
- Conflict.
  - Fetch 0x400 (same index 0): refill with 0xB0..0xB3, returns 0xB0.
  - Refetch 0x0: miss again, mem_addr restarts at 0x0.
- Stalled refill. Fetch 0x28 (offset 2), insert 3-cycle gaps between mem_rvalid beats.
  - mem_addr holds during gaps.
  - Returned data equals beat 2.
  - cpu_ready=0 throughout.
- Flush.
  - flush=1 in IDLE for 1 cycle, then fetch 0x4: miss and full refill.
  - flush pulse mid-refill: current refill completes and its word is delivered, then FLUSH; a subsequent fetch of the same line misses.
- rst_n=0 during the 2nd refill beat.
  - mem_req=0 immediately, cpu_rvalid=0.
  - After release, fetch 0x0 misses.

Source files
------------

// File: rtl/inst_cache_if.sv
// inst_cache_if: fetch-side and backing-memory-side signal bundle for inst_cache.
//   slave  modport : the cache (accepts fetches, issues refill beats)
//   master modport : the surroundings (fetch stage + backing instruction memory)
// Signals:
//   cpu_req/cpu_addr      fetch request and byte address
//   cpu_ready             cache can accept a request this cycle
//   cpu_rvalid/cpu_rdata  fetched word, one pulse per accepted request
//   flush                 invalidate all lines (level)
//   mem_req/mem_addr      refill beat request and word-aligned beat address
//   mem_rvalid/mem_rdata  returned beat
interface inst_cache_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, flush, mem_rvalid, mem_rdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, flush, mem_rvalid, mem_rdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache with 1-cycle hits and
// beat-by-beat line refill from a slower backing memory.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    inst_cache_if.slave (fetch side + refill side)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | accepting fetches; tag compare of the previous request, hits
// S_REFILL| fetching the missed line from line base, one beat per mem_rvalid
// S_RESP  | delivering the captured missed word for one cycle
// S_FLUSH | clearing every valid bit in one cycle
module inst_cache #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int LINES      = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_cache_if.slave  bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W - 2;
    localparam int RAM_AW = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP, S_FLUSH} state_t;

    state_t              r_state;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag [LINES];
    logic [31:0]         r_ram [LINES*LINE_WORDS];
    logic [31:0]         r_ram_q;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_addr;
    logic [OFF_W-1:0]    r_cnt;
    logic                r_flush_pend;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_resp_vld;
    logic [31:0]         r_resp_data;

    logic [OFF_W-1:0]    w_req_off;
    logic [IDX_W-1:0]    w_req_idx;
    logic [OFF_W-1:0]    w_p_off;
    logic [IDX_W-1:0]    w_p_idx;
    logic [TAG_W-1:0]    w_p_tag;
    logic                w_hit;
    logic                w_miss;
    logic                w_ready;
    logic                w_accept;
    logic                w_beat;
    logic                w_last;
    logic [OFF_W-1:0]    w_cnt_nxt;

    assign w_req_off = bus.cpu_addr[OFF_W+1:2];
    assign w_req_idx = bus.cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign w_p_off   = r_addr[OFF_W+1:2];
    assign w_p_idx   = r_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign w_p_tag   = r_addr[ADDR_W-1:OFF_W+IDX_W+2];

    // r_pend is only ever set while in S_IDLE, so hit/miss are IDLE-only.
    assign w_hit     = r_pend & r_valid[w_p_idx] & (r_tag[w_p_idx] == w_p_tag);
    assign w_miss    = r_pend & ~w_hit;
    assign w_ready   = (r_state == S_IDLE) & ~bus.flush & ~w_miss;
    assign w_accept  = bus.cpu_req & w_ready;
    assign w_beat    = (r_state == S_REFILL) & bus.mem_rvalid;
    assign w_last    = w_beat & (r_cnt == LAST_BEAT);
    assign w_cnt_nxt = r_cnt + 1'b1;

    assign bus.cpu_ready  = w_ready;
    // Hit path and refill response are mutually exclusive by state.
    assign bus.cpu_rvalid = w_hit | r_resp_vld;
    assign bus.cpu_rdata  = w_hit ? r_ram_q : r_resp_data;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_pend       <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_resp_vld   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pend <= 1'b1;
                        r_addr <= bus.cpu_addr;
                    end
                    if (w_miss) begin
                        // The resident line is being overwritten: drop it now so
                        // an interrupted refill can never leave a stale hit.
                        r_valid[w_p_idx] <= 1'b0;
                        r_state          <= S_REFILL;
                        r_cnt            <= '0;
                        r_mem_req        <= 1'b1;
                        r_mem_addr       <= {w_p_tag, w_p_idx, {OFF_W{1'b0}}, 2'b00};
                        if (bus.flush) r_flush_pend <= 1'b1;
                    end else if (bus.flush) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_REFILL: begin
                    if (bus.flush) r_flush_pend <= 1'b1;
                    if (bus.mem_rvalid) begin
                        if (r_cnt == w_p_off) r_resp_data <= bus.mem_rdata;
                        r_cnt      <= w_cnt_nxt;
                        r_mem_addr <= {w_p_tag, w_p_idx, w_cnt_nxt, 2'b00};
                        if (r_cnt == LAST_BEAT) begin
                            r_valid[w_p_idx] <= 1'b1;
                            r_mem_req        <= 1'b0;
                            r_resp_vld       <= 1'b1;
                            r_state          <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_resp_vld <= 1'b0;
                    if (r_flush_pend || bus.flush) r_state <= S_FLUSH;
                    else                           r_state <= S_IDLE;
                end
                S_FLUSH: begin
                    r_valid      <= '0;
                    r_flush_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data RAM (synchronous read) and tag store; no reset needed since the
    // valid vector gates every use.
    always_ff @(posedge clk) begin
        if (w_beat)   r_ram[RAM_AW'({w_p_idx, r_cnt})] <= bus.mem_rdata;
        if (w_accept) r_ram_q <= r_ram[RAM_AW'({w_req_idx, w_req_off})];
        if (w_last)   r_tag[w_p_idx] <= w_p_tag;
    end
endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;
    localparam int LW    = 4;
    localparam int LINES = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_cache_if #(.ADDR_W(32)) bus ();

    inst_cache #(.ADDR_W(32), .LINE_WORDS(LW), .LINES(LINES)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Backing memory: sparse overrides over a hashed default.
    logic [31:0] bmem [logic [31:0]];

    // Reference model: what each line index currently holds.
    bit          ref_valid [LINES];
    logic [31:0] ref_tag   [LINES];
    logic [31:0] ref_line  [LINES][LW];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bm(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 4) % LINES);
    endfunction
    function automatic int off_of(input logic [31:0] a);
        return int'((a >> 2) % LW);
    endfunction
    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> 10;
    endfunction

    task automatic model_invalidate();
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    endtask

    // One fetch; on a miss the bench plays backing memory with 'gap' idle
    // cycles before every beat, optionally pulsing flush or reset at a beat.
    task automatic do_fetch(input logic [31:0] a, input int gap, input int fl_beat, input int rst_beat);
        int          idx;
        int          off;
        logic [31:0] base;
        logic [31:0] ba;
        bit          hit;
        bit          flp;
        idx  = idx_of(a);
        off  = off_of(a);
        base = a & ~32'hF;
        hit  = ref_valid[idx] && (ref_tag[idx] == tag_of(a));
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = a; #1;
        chk("ready_idle", {31'b0, bus.cpu_ready}, 32'd1);
        @(negedge clk);
        bus.cpu_req = 1'b0; #1;
        if (hit) begin
            chk("hit_rvalid", {31'b0, bus.cpu_rvalid}, 32'd1);
            chk("hit_rdata", bus.cpu_rdata, ref_line[idx][off]);
            chk("hit_memreq", {31'b0, bus.mem_req}, 32'd0);
            return;
        end
        chk("miss_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        chk("miss_ready", {31'b0, bus.cpu_ready}, 32'd0);
        ref_valid[idx] = 1'b0;
        flp = 1'b0;
        for (int b = 0; b < LW; b++) begin
            ba = base + 32'(4 * b);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.mem_rvalid = 1'b0; bus.flush = 1'b0; #1;
                chk("gap_memreq", {31'b0, bus.mem_req}, 32'd1);
                chk("gap_memaddr", bus.mem_addr, ba);
                chk("gap_ready", {31'b0, bus.cpu_ready}, 32'd0);
                chk("gap_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
            end
            @(negedge clk);
            bus.mem_rvalid = 1'b1; bus.mem_rdata = bm(ba); bus.flush = 1'b0;
            if (b == fl_beat) begin bus.flush = 1'b1; flp = 1'b1; end
            if (b == rst_beat) rst_n = 1'b0;
            #1;
            if (b == rst_beat) begin
                chk("rst_memreq", {31'b0, bus.mem_req}, 32'd0);
                chk("rst_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1; #1;             // late beat still presented
                @(negedge clk);
                bus.mem_rvalid = 1'b0; #1;
                chk("late_memreq", {31'b0, bus.mem_req}, 32'd0);
                chk("late_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
                model_invalidate();
                return;
            end
            chk("beat_memreq", {31'b0, bus.mem_req}, 32'd1);
            chk("beat_memaddr", bus.mem_addr, ba);
            chk("beat_ready", {31'b0, bus.cpu_ready}, 32'd0);
            ref_line[idx][b] = bm(ba);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.flush = 1'b0; #1;
        chk("resp_rvalid", {31'b0, bus.cpu_rvalid}, 32'd1);
        chk("resp_rdata", bus.cpu_rdata, ref_line[idx][off]);
        chk("resp_memreq", {31'b0, bus.mem_req}, 32'd0);
        chk("resp_ready", {31'b0, bus.cpu_ready}, 32'd0);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag_of(a);
        if (flp) begin
            @(negedge clk); #1;
            chk("pflush_ready", {31'b0, bus.cpu_ready}, 32'd0);
            chk("pflush_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
            model_invalidate();
        end
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.flush = 1'b1; #1;
        chk("flush_ready0", {31'b0, bus.cpu_ready}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0; #1;
        chk("flush_ready1", {31'b0, bus.cpu_ready}, 32'd0);
        model_invalidate();
    endtask

    // Back-to-back fetches expected to hit, one per cycle.
    task automatic fetch_stream(input logic [31:0] a0, input int n);
        logic [31:0] prev;
        prev = '0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i < n) begin bus.cpu_req = 1'b1; bus.cpu_addr = a0 + 32'(4 * i); end
            else       bus.cpu_req = 1'b0;
            #1;
            if (i > 0) begin
                chk("stream_rvalid", {31'b0, bus.cpu_rvalid}, 32'd1);
                chk("stream_rdata", bus.cpu_rdata, ref_line[idx_of(prev)][off_of(prev)]);
                chk("stream_memreq", {31'b0, bus.mem_req}, 32'd0);
            end
            if (i < n) chk("stream_ready", {31'b0, bus.cpu_ready}, 32'd1);
            prev = a0 + 32'(4 * i);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          fb;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        model_invalidate();
        for (int i = 0; i < LW; i++) begin
            bmem[32'(4 * i)]         = 32'hA0 + 32'(i);
            bmem[32'h400 + 32'(4 * i)] = 32'hB0 + 32'(i);
        end

        #12;
        chk("rst_ready", {31'b0, bus.cpu_ready}, 32'd1);
        chk("rst_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        chk("rst_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_memreq", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_memaddr", bus.mem_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Defaults, then back-to-back hits in the same line.
        do_fetch(32'h0, 0, -1, -1);
        fetch_stream(32'h4, 3);
        // Conflict in index 0 and refetch of the evicted line.
        do_fetch(32'h400, 0, -1, -1);
        do_fetch(32'h0, 0, -1, -1);
        // Stalled refill returning beat 2.
        do_fetch(32'h28, 3, -1, -1);
        // Flush in idle, then a miss on a previously resident line.
        do_flush();
        do_fetch(32'h4, 0, -1, -1);
        // Flush mid-refill, then the same line must miss.
        do_fetch(32'h44, 1, 1, -1);
        do_fetch(32'h44, 0, -1, -1);
        // Reset during the second beat, then a miss after release.
        do_fetch(32'h0, 0, -1, 1);
        do_fetch(32'h0, 0, -1, -1);

        // Randomized traffic over a small footprint to mix hits and conflicts.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush();
            end else begin
                a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
                    (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
                do_fetch(a, int'($urandom_range(0, 2)), fb, -1);
            end
            if ($urandom_range(0, 4) == 0)
                bmem[(32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 31)) << 2)] = $urandom;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
